// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants for the common-data-bus arbiter slice.
//   - CDB_ROB_ADDR_W : default ROB index width carried with each result
//   - CDB_VAL_W      : result value width
//   - CDB_FIFO_DEPTH : default entries per producer FIFO
//   - CDB entry layout, packed MSB first: {robid, val}
//   - cdb_src_e      : producer encodings, SRC_ALU=0, SRC_LSB=1
package cdb_arbiter_pkg;

   localparam int unsigned CDB_ROB_ADDR_W = 5;
   localparam int unsigned CDB_VAL_W      = 32;
   localparam int unsigned CDB_FIFO_DEPTH = 4;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } cdb_src_e;

   // Round-robin partner of a source.
   function automatic cdb_src_e other_src(input cdb_src_e s);
      return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
//   Small synchronous FIFO holding one producer's pending CDB results.
//   Ports:
//     clk   : clock
//     rst   : synchronous active-high reset
//     en    : global enable; low freezes all state
//     clr   : discard all entries (wins over push/pop)
//     push  : write din at the tail
//     pop   : drop the head entry
//     din   : entry to write
//     dout  : current head entry (valid when count != 0)
//     count : number of stored entries, 0..DEPTH
//   A push into a full FIFO is only accepted when the head is popped in the
//   same cycle; otherwise the entry is dropped and an assertion fires.
module cdb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 37
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      // Full is fine as long as the head leaves in the same cycle.
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      if (en) begin
         if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (do_push) begin
               mem_d[wr_ptr_q] = din;
               wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   overflow_chk: assert property (@(posedge clk) disable iff (rst)
      !(en && !clr && push && !pop && (count_q == FULL_CNT)));

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Schedules the single common data bus shared by the ALU and the LSB.
//   Each producer queues results in its own cdb_fifo; a round-robin arbiter
//   pops one entry per cycle into registered broadcast outputs.
//   Ports:
//     clk_in, rst_in (sync, active-high), rdy_in (low freezes everything)
//     flush                  : discard all queued and incoming results
//     alu_valid/robid/val    : ALU result input
//     lsb_valid/robid/val    : LSB result input
//     alu_stall, lsb_stall   : back-pressure, high when count >= DEPTH-2
//     cdb_valid/robid/val    : registered broadcast
//   Build option: define CDB_BYPASS_EN to let a result arriving at an empty
//   FIFO compete directly in arbitration and reach the CDB one cycle sooner.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned ROB_ADDR_W = CDB_ROB_ADDR_W,
   parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush,
   input  logic                  alu_valid,
   input  logic [ROB_ADDR_W-1:0] alu_robid,
   input  logic [31:0]           alu_val,
   input  logic                  lsb_valid,
   input  logic [ROB_ADDR_W-1:0] lsb_robid,
   input  logic [31:0]           lsb_val,
   output logic                  alu_stall,
   output logic                  lsb_stall,
   output logic                  cdb_valid,
   output logic [ROB_ADDR_W-1:0] cdb_robid,
   output logic [31:0]           cdb_val
);

   localparam int unsigned ENTRY_W = ROB_ADDR_W + CDB_VAL_W;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 2);

   logic [CNT_W-1:0]   alu_count, lsb_count;
   logic [ENTRY_W-1:0] alu_head, lsb_head;
   logic               alu_push, alu_pop, lsb_push, lsb_pop;
   logic               alu_empty, lsb_empty;
   logic               alu_byp, lsb_byp;
   logic               alu_req, lsb_req;
   logic               grant_any;
   cdb_src_e           grant_src;
   logic [ENTRY_W-1:0] grant_data;

   cdb_src_e              last_grant_q, last_grant_d;
   logic                  cdb_valid_q, cdb_valid_d;
   logic [ROB_ADDR_W-1:0] cdb_robid_q, cdb_robid_d;
   logic [31:0]           cdb_val_q, cdb_val_d;

   cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_alu_fifo (
      .clk   (clk_in),
      .rst   (rst_in),
      .en    (rdy_in),
      .clr   (flush),
      .push  (alu_push),
      .pop   (alu_pop),
      .din   ({alu_robid, alu_val}),
      .dout  (alu_head),
      .count (alu_count)
   );

   cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_lsb_fifo (
      .clk   (clk_in),
      .rst   (rst_in),
      .en    (rdy_in),
      .clr   (flush),
      .push  (lsb_push),
      .pop   (lsb_pop),
      .din   ({lsb_robid, lsb_val}),
      .dout  (lsb_head),
      .count (lsb_count)
   );

   always_comb begin
      alu_empty = (alu_count == '0);
      lsb_empty = (lsb_count == '0);
`ifdef CDB_BYPASS_EN
      // An incoming result at an empty FIFO acts as a virtual head.
      alu_byp = alu_valid && alu_empty;
      lsb_byp = lsb_valid && lsb_empty;
`else
      alu_byp = 1'b0;
      lsb_byp = 1'b0;
`endif
      alu_req = !alu_empty || alu_byp;
      lsb_req = !lsb_empty || lsb_byp;

      grant_any = alu_req || lsb_req;
      grant_src = SRC_ALU;
      if (alu_req && lsb_req) begin
         grant_src = other_src(last_grant_q);
      end else if (lsb_req) begin
         grant_src = SRC_LSB;
      end

      if (grant_src == SRC_ALU) begin
         grant_data = alu_empty ? {alu_robid, alu_val} : alu_head;
      end else begin
         grant_data = lsb_empty ? {lsb_robid, lsb_val} : lsb_head;
      end

      // A bypassed winner skips its FIFO; a losing input is queued as usual.
      alu_pop  = grant_any && (grant_src == SRC_ALU) && !alu_empty;
      lsb_pop  = grant_any && (grant_src == SRC_LSB) && !lsb_empty;
      alu_push = alu_valid && !(grant_any && (grant_src == SRC_ALU) && alu_byp);
      lsb_push = lsb_valid && !(grant_any && (grant_src == SRC_LSB) && lsb_byp);

      last_grant_d = last_grant_q;
      cdb_valid_d  = cdb_valid_q;
      cdb_robid_d  = cdb_robid_q;
      cdb_val_d    = cdb_val_q;
      if (rdy_in) begin
         if (flush) begin
            cdb_valid_d = 1'b0;
         end else begin
            cdb_valid_d = grant_any;
            if (grant_any) begin
               last_grant_d = grant_src;
               cdb_robid_d  = grant_data[ENTRY_W-1 -: ROB_ADDR_W];
               cdb_val_d    = grant_data[CDB_VAL_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant_q <= SRC_LSB;
         cdb_valid_q  <= 1'b0;
         cdb_robid_q  <= '0;
         cdb_val_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_robid_q  <= cdb_robid_d;
         cdb_val_q    <= cdb_val_d;
      end
   end

   assign alu_stall = (alu_count >= STALL_CNT);
   assign lsb_stall = (lsb_count >= STALL_CNT);
   assign cdb_valid = cdb_valid_q;
   assign cdb_robid = cdb_robid_q;
   assign cdb_val   = cdb_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   localparam int RW = 5;
   localparam int D  = 4;
`ifdef CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, rdy, flush;
   logic          av, lv;
   logic [RW-1:0] arob, lrob;
   logic [31:0]   aval, lval;
   logic          alu_stall, lsb_stall, cdb_valid;
   logic [RW-1:0] cdb_robid;
   logic [31:0]   cdb_val;

   cdb_arbiter #(.ROB_ADDR_W(RW), .FIFO_DEPTH(D)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .rdy_in    (rdy),
      .flush     (flush),
      .alu_valid (av),
      .alu_robid (arob),
      .alu_val   (aval),
      .lsb_valid (lv),
      .lsb_robid (lrob),
      .lsb_val   (lval),
      .alu_stall (alu_stall),
      .lsb_stall (lsb_stall),
      .cdb_valid (cdb_valid),
      .cdb_robid (cdb_robid),
      .cdb_val   (cdb_val)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: per-source queues of {robid,val}, last winner, CDB regs.
   logic [RW+31:0] qa[$];
   logic [RW+31:0] ql[$];
   bit             m_last_lsb;
   bit             m_v;
   logic [RW-1:0]  m_rob;
   logic [31:0]    m_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      bit ba, bl, ca, cl;
      int g;
      logic [RW+31:0] e;
      if (rst) begin
         qa.delete(); ql.delete();
         m_last_lsb = 1'b1; m_v = 1'b0; m_rob = '0; m_val = '0;
         return;
      end
      if (!rdy) return;
      if (flush) begin
         qa.delete(); ql.delete();
         m_v = 1'b0;
         return;
      end
      ba = BYP && av && (qa.size() == 0);
      bl = BYP && lv && (ql.size() == 0);
      ca = (qa.size() > 0) || ba;
      cl = (ql.size() > 0) || bl;
      g = -1;
      if (ca && cl) g = m_last_lsb ? 0 : 1;
      else if (ca)  g = 0;
      else if (cl)  g = 1;
      m_v = (g >= 0);
      if (g == 0) begin
         if (ba) e = {arob, aval};
         else    e = qa.pop_front();
         m_last_lsb = 1'b0;
         {m_rob, m_val} = e;
      end else if (g == 1) begin
         if (bl) e = {lrob, lval};
         else    e = ql.pop_front();
         m_last_lsb = 1'b1;
         {m_rob, m_val} = e;
      end
      if (av && !(g == 0 && ba) && qa.size() < D) qa.push_back({arob, aval});
      if (lv && !(g == 1 && bl) && ql.size() < D) ql.push_back({lrob, lval});
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("cdb_valid", 32'(cdb_valid), 32'(m_v));
      check("cdb_robid", 32'(cdb_robid), 32'(m_rob));
      check("cdb_val",   cdb_val, m_val);
      check("alu_stall", 32'(alu_stall), 32'(qa.size() >= D - 2));
      check("lsb_stall", 32'(lsb_stall), 32'(ql.size() >= D - 2));
   endtask

   task automatic idle_in();
      av = 1'b0; lv = 1'b0; flush = 1'b0;
      arob = '0; aval = '0; lrob = '0; lval = '0;
   endtask

   typedef struct {
      bit av; logic [RW-1:0] ar; logic [31:0] avl;
      bit lv; logic [RW-1:0] lr; logic [31:0] lvl;
      bit fl;
      bit ev; logic [RW-1:0] er; logic [31:0] evl;
      bit eas; bit els;
   } vec_t;

   function automatic vec_t mk(bit a, logic [RW-1:0] ar, logic [31:0] avl,
                               bit l, logic [RW-1:0] lr, logic [31:0] lvl, bit fl,
                               bit ev, logic [RW-1:0] er, logic [31:0] evl,
                               bit eas, bit els);
      vec_t v;
      v.av = a; v.ar = ar; v.avl = avl; v.lv = l; v.lr = lr; v.lvl = lvl; v.fl = fl;
      v.ev = ev; v.er = er; v.evl = evl; v.eas = eas; v.els = els;
      return v;
   endfunction

   vec_t tbl[11];
   bit   pa, pl;
   logic [RW-1:0] atag, ltag;

   initial begin
      // Directed rows: single result, contention, flush with a same-cycle push.
`ifdef CDB_BYPASS_EN
      tbl[0]  = mk(1, 3, 'h11, 0, 0, 0,     0, 1, 3,  'h11, 0, 0);
      tbl[1]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 3,  'h11, 0, 0);
      tbl[2]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 3,  'h11, 0, 0);
      tbl[3]  = mk(1, 1, 'hA1, 1, 17, 'hB1, 0, 1, 17, 'hB1, 0, 0);
      tbl[4]  = mk(1, 2, 'hA2, 1, 18, 'hB2, 0, 1, 1,  'hA1, 0, 0);
      tbl[5]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 18, 'hB2, 0, 0);
      tbl[6]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 2,  'hA2, 0, 0);
      tbl[7]  = mk(1, 7, 'h77, 0, 0, 0,     1, 0, 2,  'hA2, 0, 0);
      tbl[8]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 2,  'hA2, 0, 0);
      tbl[9]  = mk(0, 0, 0,    1, 20, 'hC0, 0, 1, 20, 'hC0, 0, 0);
      tbl[10] = mk(0, 0, 0,    0, 0, 0,     0, 0, 20, 'hC0, 0, 0);
`else
      tbl[0]  = mk(1, 3, 'h11, 0, 0, 0,     0, 0, 0,  0,    0, 0);
      tbl[1]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 3,  'h11, 0, 0);
      tbl[2]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 3,  'h11, 0, 0);
      tbl[3]  = mk(1, 1, 'hA1, 1, 17, 'hB1, 0, 0, 3,  'h11, 0, 0);
      tbl[4]  = mk(1, 2, 'hA2, 1, 18, 'hB2, 0, 1, 17, 'hB1, 1, 0);
      tbl[5]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 1,  'hA1, 0, 0);
      tbl[6]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 18, 'hB2, 0, 0);
      tbl[7]  = mk(1, 7, 'h77, 0, 0, 0,     1, 0, 18, 'hB2, 0, 0);
      tbl[8]  = mk(0, 0, 0,    0, 0, 0,     0, 0, 18, 'hB2, 0, 0);
      tbl[9]  = mk(0, 0, 0,    1, 20, 'hC0, 0, 0, 18, 'hB2, 0, 0);
      tbl[10] = mk(0, 0, 0,    0, 0, 0,     0, 1, 20, 'hC0, 0, 0);
`endif

      rst = 1'b1; rdy = 1'b1;
      idle_in();
      #2;
      step();
      step();
      check("reset_valid", 32'(cdb_valid), 32'd0);
      check("reset_robid", 32'(cdb_robid), 32'd0);
      check("reset_val",   cdb_val, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         av = tbl[i].av; arob = tbl[i].ar; aval = tbl[i].avl;
         lv = tbl[i].lv; lrob = tbl[i].lr; lval = tbl[i].lvl;
         flush = tbl[i].fl;
         step();
         check("tbl_valid", 32'(cdb_valid), 32'(tbl[i].ev));
         check("tbl_robid", 32'(cdb_robid), 32'(tbl[i].er));
         check("tbl_val",   cdb_val, tbl[i].evl);
         check("tbl_alu_stall", 32'(alu_stall), 32'(tbl[i].eas));
         check("tbl_lsb_stall", 32'(lsb_stall), 32'(tbl[i].els));
      end
      idle_in();

      // Freeze with entries queued: garbage inputs and a flush must be ignored.
      av = 1; arob = 4; aval = 'h44; lv = 1; lrob = 21; lval = 'h55;
      step();
      av = 1; arob = 5; aval = 'h45; lv = 1; lrob = 22; lval = 'h56;
      step();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         av = 1; arob = 9; aval = $urandom; lv = 1; lrob = 29; lval = $urandom;
         flush = (i == 1);
         step();
      end
      rdy = 1'b1;
      idle_in();
      for (int i = 0; i < 5; i++) step();

      // Reset in the middle of traffic, then the first grant must go to ALU.
      av = 1; arob = 6; aval = 'h66; lv = 1; lrob = 23; lval = 'h77;
      step();
      rst = 1'b1;
      step();
      check("rst_mid_valid", 32'(cdb_valid), 32'd0);
      check("rst_mid_alu_stall", 32'(alu_stall), 32'd0);
      rst = 1'b0;
      av = 1; arob = 8; aval = 'h88; lv = 1; lrob = 24; lval = 'h99;
      step();
      idle_in();
      if (!BYP) step();
      check("rst_first_grant", 32'(cdb_robid), 32'd8);
      for (int i = 0; i < 4; i++) step();

      // Random traffic, producers honour stall with one decision per cycle.
      pa = 0; pl = 0; atag = 0; ltag = 16;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         rdy   = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 39) == 0);
         av = pa; arob = atag; aval = $urandom;
         lv = pl; lrob = ltag; lval = $urandom;
         step();
         if (rst || rdy) begin
            if (av) atag = (atag == 15) ? 5'd0 : atag + 5'd1;
            if (lv) ltag = (ltag == 31) ? 5'd16 : ltag + 5'd1;
            pa = !alu_stall && ($urandom_range(0, 99) < 60);
            pl = !lsb_stall && ($urandom_range(0, 99) < 60);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
